// File: rtl/logic_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : logic_bist_pkg
//  Purpose  : Shared types and constants for the logic BIST engine: FSM state
//             encoding, fault-site net codes and the stuck-at override helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package logic_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    // Fault-site codes for the internal nets of the test network
    localparam logic [3:0] NET_D    = 4'd0;
    localparam logic [3:0] NET_P    = 4'd1;
    localparam logic [3:0] NET_G    = 4'd2;
    localparam logic [3:0] NET_J    = 4'd3;
    localparam logic [3:0] NET_W    = 4'd4;
    localparam logic [3:0] NET_X    = 4'd5;
    localparam logic [3:0] NET_Q    = 4'd6;
    localparam logic [3:0] NET_K    = 4'd7;
    localparam logic [3:0] NET_Y    = 4'd8;
    localparam logic [3:0] NET_Z    = 4'd9;
    localparam logic [3:0] NET_NONE = 4'd10;

    // Returns the stuck value when this net is the selected fault site,
    // otherwise the fault-free value. Codes 10..15 never match any net.
    function automatic logic net_force(
        input logic       val,
        input logic       en,
        input logic [3:0] net,
        input logic [3:0] code,
        input logic       stuck
    );
        return (en && (net == code)) ? stuck : val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_net_flt.sv
`default_nettype none
// ============================================================================
//  Module   : logic_net_flt
//  Purpose  : One copy of the 5-input / 2-output test network with a single
//             stuck-at fault site. Downstream nets see the forced value.
//  Ports    : a,b,c,e,h  network inputs
//             flt_en     enable fault injection
//             flt_net    fault-site code (10..15 = no fault)
//             flt_val    stuck value
//             z,y        network outputs
//  Revision : 1.0 - initial release
// ============================================================================
module logic_net_flt
    import logic_bist_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       e,
    input  logic       h,
    input  logic       flt_en,
    input  logic [3:0] flt_net,
    input  logic       flt_val,
    output logic       z,
    output logic       y
);

    logic w_d, w_p, w_g, w_j, w_w, w_x, w_q, w_k;

    assign w_d = net_force(a | b,         flt_en, flt_net, NET_D, flt_val);
    assign w_p = net_force(w_d & e,       flt_en, flt_net, NET_P, flt_val);
    assign w_g = net_force(~w_p,          flt_en, flt_net, NET_G, flt_val);
    assign w_j = net_force(w_g | h,       flt_en, flt_net, NET_J, flt_val);
    assign w_w = net_force(~(b & w_j),    flt_en, flt_net, NET_W, flt_val);
    assign w_x = net_force(w_j & w_g,     flt_en, flt_net, NET_X, flt_val);
    assign w_q = net_force(~w_d,          flt_en, flt_net, NET_Q, flt_val);
    assign w_k = net_force(~(w_q | c),    flt_en, flt_net, NET_K, flt_val);
    assign z   = net_force(w_w & w_x,     flt_en, flt_net, NET_Z, flt_val);
    assign y   = net_force(w_k | a,       flt_en, flt_net, NET_Y, flt_val);

endmodule
`default_nettype wire

// File: rtl/logic_bist_engine.sv
`default_nettype none
// ============================================================================
//  Module   : logic_bist_engine
//  Purpose  : Logic BIST engine. Drives LFSR patterns into CHANNELS faultable
//             network copies and CHANNELS clean copies, compacts the faulty
//             responses into a MISR and records the first faulty/clean
//             mismatch of the run.
//  Ports    : clk, rst_n          clock, synchronous active-low reset
//             start, abort        run control (abort wins)
//             flt_en/chan/net/val fault configuration, captured at run start
//             golden_sig          expected signature
//             busy, done, pass    status
//             signature           MISR contents
//             detected            sticky mismatch flag
//             first_fail_idx      pattern index of first mismatch
//  Revision : 1.0 - initial release
// ============================================================================
module logic_bist_engine
    import logic_bist_pkg::*;
#(
    parameter int                      CHANNELS  = 4,
    parameter int                      PAT_COUNT = 64,
    parameter int                      LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]       LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0]       SEED      = 16'hACE1,
    parameter logic [2*CHANNELS-1:0]   MISR_POLY = 8'h1D,
    localparam int                     CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int                     CNT_W     = $clog2(PAT_COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  flt_en,
    input  logic [CH_W-1:0]       flt_chan,
    input  logic [3:0]            flt_net,
    input  logic                  flt_val,
    input  logic [2*CHANNELS-1:0] golden_sig,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2*CHANNELS-1:0] signature,
    output logic                  detected,
    output logic [CNT_W-1:0]      first_fail_idx
);

    localparam int W = 2 * CHANNELS;

    if (SEED == '0) begin : g_seed_check
        $error("logic_bist_engine: SEED must be nonzero");
    end

    bist_state_t        r_state;
    bist_state_t        w_state_next;
    logic               w_run_entry;

    logic [LFSR_W-1:0]  r_lfsr;
    logic [W-1:0]       r_misr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_detected;
    logic [CNT_W-1:0]   r_first_fail;
    logic               r_flt_en;
    logic [CH_W-1:0]    r_flt_chan;
    logic [3:0]         r_flt_net;
    logic               r_flt_val;

    logic [W-1:0]       w_resp_flt;
    logic [W-1:0]       w_resp_clean;
    logic               w_last;

    assign w_last = (r_cnt == CNT_W'(PAT_COUNT - 1));

    // ------------------------------------------------------------------
    // Network copies: channel n sees LFSR bits 5n..5n+4 (wrapping)
    // ------------------------------------------------------------------
    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        logic [4:0] w_in;
        logic       w_sel;

        for (genvar i = 0; i < 5; i++) begin : g_bit
            assign w_in[i] = r_lfsr[(5 * n + i) % LFSR_W];
        end

        // Out-of-range channel numbers simply never match
        assign w_sel = r_flt_en && (int'(r_flt_chan) == n);

        logic_net_flt u_flt (
            .a       (w_in[0]),
            .b       (w_in[1]),
            .c       (w_in[2]),
            .e       (w_in[3]),
            .h       (w_in[4]),
            .flt_en  (w_sel),
            .flt_net (r_flt_net),
            .flt_val (r_flt_val),
            .z       (w_resp_flt[2*n+1]),
            .y       (w_resp_flt[2*n])
        );

        logic_net_flt u_clean (
            .a       (w_in[0]),
            .b       (w_in[1]),
            .c       (w_in[2]),
            .e       (w_in[3]),
            .h       (w_in[4]),
            .flt_en  (1'b0),
            .flt_net (NET_NONE),
            .flt_val (1'b0),
            .z       (w_resp_clean[2*n+1]),
            .y       (w_resp_clean[2*n])
        );
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_run_entry  = 1'b0;
        if (abort) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_next = RUN;
                        w_run_entry  = 1'b1;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        w_state_next = DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        w_state_next = RUN;
                        w_run_entry  = 1'b1;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: LFSR, MISR, pattern counter, mismatch capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr       <= SEED;
            r_misr       <= '0;
            r_cnt        <= '0;
            r_detected   <= 1'b0;
            r_first_fail <= '0;
            r_flt_en     <= 1'b0;
            r_flt_chan   <= '0;
            r_flt_net    <= '0;
            r_flt_val    <= 1'b0;
        end else if (w_run_entry) begin
            r_lfsr       <= SEED;
            r_misr       <= '0;
            r_cnt        <= '0;
            r_detected   <= 1'b0;
            r_first_fail <= '0;
            r_flt_en     <= flt_en;
            r_flt_chan   <= flt_chan;
            r_flt_net    <= flt_net;
            r_flt_val    <= flt_val;
        end else if ((r_state == RUN) && !abort) begin
            // On an abort cycle the partial results are frozen as they stand
            r_misr <= {r_misr[W-2:0], 1'b0}
                    ^ (r_misr[W-1] ? MISR_POLY : '0)
                    ^ w_resp_flt;
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
            r_cnt  <= r_cnt + CNT_W'(1);
            if ((w_resp_flt != w_resp_clean) && !r_detected) begin
                r_detected   <= 1'b1;
                r_first_fail <= r_cnt;
            end
        end
    end

    assign busy           = (r_state == RUN);
    assign done           = (r_state == DONE);
    assign pass           = done && (r_misr == golden_sig);
    assign signature      = r_misr;
    assign detected       = r_detected;
    assign first_fail_idx = r_first_fail;

endmodule
`default_nettype wire

// File: tb/tb_logic_bist_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_bist_engine
//  Purpose  : Self-checking bench for logic_bist_engine. A 4-channel/64-pattern
//             instance is exercised with fixed and random fault configurations;
//             a 4-channel/1-pattern instance with a hand-picked seed is driven
//             from a table of single-vector fault cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_logic_bist_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic       rst_n, start, abort, flt_en, flt_val;
    logic [1:0] flt_chan;
    logic [3:0] flt_net;
    logic [7:0] golden_sig;
    logic       busy, done, pass, detected;
    logic [7:0] signature;
    logic [6:0] first_fail_idx;

    // Single-pattern instance
    logic       o_start, o_abort, o_flt_en, o_flt_val;
    logic [1:0] o_flt_chan;
    logic [3:0] o_flt_net;
    logic [7:0] o_golden;
    logic       o_busy, o_done, o_pass, o_detected;
    logic [7:0] o_signature;
    logic [0:0] o_ffi;

    int errors = 0;
    int checks = 0;

    logic_bist_engine #(
        .CHANNELS(4), .PAT_COUNT(64), .LFSR_W(16),
        .LFSR_TAPS(16'hB400), .SEED(16'hACE1), .MISR_POLY(8'h1D)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .flt_en(flt_en), .flt_chan(flt_chan), .flt_net(flt_net), .flt_val(flt_val),
        .golden_sig(golden_sig), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .detected(detected), .first_fail_idx(first_fail_idx)
    );

    // Seed 0x000A puts a=0,b=1,c=0,e=1,h=0 on channel 0
    logic_bist_engine #(
        .CHANNELS(4), .PAT_COUNT(1), .LFSR_W(16),
        .LFSR_TAPS(16'hB400), .SEED(16'h000A), .MISR_POLY(8'h1D)
    ) u_one (
        .clk(clk), .rst_n(rst_n), .start(o_start), .abort(o_abort),
        .flt_en(o_flt_en), .flt_chan(o_flt_chan), .flt_net(o_flt_net), .flt_val(o_flt_val),
        .golden_sig(o_golden), .busy(o_busy), .done(o_done), .pass(o_pass),
        .signature(o_signature), .detected(o_detected), .first_fail_idx(o_ffi)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    // Evaluates the network net by net; fnet<0 means no fault.
    function automatic bit [1:0] net_eval(input bit [4:0] in, input int fnet, input bit v);
        bit nv[10];
        bit a, b, c, e, h;
        a = in[0]; b = in[1]; c = in[2]; e = in[3]; h = in[4];
        nv[0] = a | b;              if (fnet == 0) nv[0] = v;   // d
        nv[1] = nv[0] & e;          if (fnet == 1) nv[1] = v;   // p
        nv[2] = !nv[1];             if (fnet == 2) nv[2] = v;   // g
        nv[3] = nv[2] | h;          if (fnet == 3) nv[3] = v;   // j
        nv[4] = !(b & nv[3]);       if (fnet == 4) nv[4] = v;   // w
        nv[5] = nv[3] & nv[2];      if (fnet == 5) nv[5] = v;   // x
        nv[6] = !nv[0];             if (fnet == 6) nv[6] = v;   // q
        nv[7] = !(nv[6] | c);       if (fnet == 7) nv[7] = v;   // k
        nv[8] = nv[7] | a;          if (fnet == 8) nv[8] = v;   // y
        nv[9] = nv[4] & nv[5];      if (fnet == 9) nv[9] = v;   // z
        return {nv[9], nv[8]};
    endfunction

    function automatic void model(input bit [15:0] seed, input int pats,
                                  input bit en, input int ch, input int net, input bit v,
                                  output bit [7:0] sig, output bit det, output int ffi);
        bit [15:0] lfsr;
        bit [7:0]  rf, rc;
        bit [4:0]  in;
        int        fn;
        lfsr = seed; sig = 0; det = 0; ffi = 0;
        for (int p = 0; p < pats; p++) begin
            for (int n = 0; n < 4; n++) begin
                for (int i = 0; i < 5; i++) in[i] = lfsr[(5 * n + i) % 16];
                fn = (en && ch == n && net < 10) ? net : -1;
                {rf[2*n+1], rf[2*n]} = net_eval(in, fn, v);
                {rc[2*n+1], rc[2*n]} = net_eval(in, -1, 1'b0);
            end
            sig = {sig[6:0], 1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ rf;
            if (rf != rc && !det) begin
                det = 1;
                ffi = p;
            end
            lfsr = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    endfunction

    // ------------------------------------------------------------------
    // Run helpers
    // ------------------------------------------------------------------
    // Full run on the main instance; config inputs are scrambled after start
    // to show they are captured. poke pulses start in the middle of the run.
    task automatic do_run(input bit en, input bit [1:0] ch, input bit [3:0] net, input bit v,
                          input bit [7:0] gold, input bit poke, output int bc);
        @(negedge clk);
        start = 1; flt_en = en; flt_chan = ch; flt_net = net; flt_val = v; golden_sig = gold;
        @(negedge clk);
        start = 0; flt_en = ~en; flt_chan = ch + 2'd1; flt_net = net ^ 4'h5; flt_val = ~v;
        bc = 0;
        while (busy === 1'b1 && bc < 200) begin
            bc++;
            start = (poke && bc == 30);
            @(negedge clk);
        end
        start = 0;
    endtask

    task automatic check_run(input string tag, input bit en, input int ch, input int net,
                             input bit v, input bit [7:0] gold, input int bc);
        bit [7:0] s; bit d; int f;
        model(16'hACE1, 64, en, ch, net, v, s, d, f);
        chk({tag, "_busy_cycles"}, bc, 64);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_sig"}, signature, s);
        chk({tag, "_det"}, detected, d);
        chk({tag, "_ffi"}, first_fail_idx, d ? f : 0);
        chk({tag, "_pass"}, pass, (s == gold));
    endtask

    typedef struct {
        bit       en;
        bit [1:0] ch;
        bit [3:0] net;
        bit       v;
        bit       exp_det;
        bit       exp_pass;
    } vec_t;

    initial begin
        vec_t     vt[7];
        bit [7:0] ff_sig, s, gold;
        bit       d;
        int       f, bc;
        bit       en, v;
        bit [1:0] ch;
        bit [3:0] net;

        // Hand-derived single-vector cases for ch0 inputs a=0,b=1,c=0,e=1,h=0
        // (fault-free: z=0, y=1)
        vt[0] = '{1'b0, 2'd0, 4'd7,  1'b0, 1'b0, 1'b1};  // fault disabled
        vt[1] = '{1'b1, 2'd0, 4'd7,  1'b0, 1'b1, 1'b0};  // k s-a-0 -> y 1->0
        vt[2] = '{1'b1, 2'd0, 4'd2,  1'b1, 1'b0, 1'b1};  // g s-a-1 masked
        vt[3] = '{1'b1, 2'd0, 4'd12, 1'b1, 1'b0, 1'b1};  // net code out of range
        vt[4] = '{1'b1, 2'd0, 4'd0,  1'b0, 1'b1, 1'b0};  // d s-a-0 -> y 1->0
        vt[5] = '{1'b1, 2'd0, 4'd9,  1'b1, 1'b1, 1'b0};  // z s-a-1 -> z 0->1
        vt[6] = '{1'b1, 2'd0, 4'd10, 1'b0, 1'b0, 1'b1};  // first "none" code

        rst_n = 0; start = 0; abort = 0; flt_en = 0; flt_chan = 0; flt_net = 0; flt_val = 0;
        golden_sig = 0;
        o_start = 0; o_abort = 0; o_flt_en = 0; o_flt_chan = 0; o_flt_net = 0; o_flt_val = 0;
        o_golden = 0;
        repeat (3) @(negedge clk);

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_sig", signature, 0);
        chk("rst_det", detected, 0);
        chk("rst_ffi", first_fail_idx, 0);
        rst_n = 1;

        // Fault-free run, then rerun against its own signature (start poked mid-run)
        model(16'hACE1, 64, 0, 0, 15, 0, ff_sig, d, f);
        do_run(0, 0, 0, 0, 8'h00, 0, bc);
        check_run("ff", 0, 0, 0, 0, 8'h00, bc);
        do_run(0, 0, 0, 0, ff_sig, 1, bc);
        check_run("ff_gold", 0, 0, 0, 0, ff_sig, bc);

        // No-fault encodings on the main instance
        do_run(1, 2, 4'd12, 1, ff_sig, 0, bc);
        check_run("net12", 1, 2, 12, 1, ff_sig, bc);
        do_run(1, 1, 4'd15, 0, ff_sig, 0, bc);
        check_run("net15", 1, 1, 15, 0, ff_sig, bc);

        // Table of single-vector cases
        model(16'h000A, 1, 0, 0, 15, 0, gold, d, f);
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            o_start = 1; o_flt_en = vt[t].en; o_flt_chan = vt[t].ch;
            o_flt_net = vt[t].net; o_flt_val = vt[t].v; o_golden = gold;
            @(negedge clk);
            o_start = 0;
            bc = 0;
            while (o_busy === 1'b1 && bc < 20) begin
                bc++;
                @(negedge clk);
            end
            model(16'h000A, 1, vt[t].en, vt[t].ch, vt[t].net, vt[t].v, s, d, f);
            chk($sformatf("vec%0d_busy_cycles", t), bc, 1);
            chk($sformatf("vec%0d_done", t), o_done, 1);
            chk($sformatf("vec%0d_det", t), o_detected, vt[t].exp_det);
            chk($sformatf("vec%0d_ffi", t), o_ffi, 0);
            chk($sformatf("vec%0d_pass", t), o_pass, vt[t].exp_pass);
            chk($sformatf("vec%0d_sig", t), o_signature, s);
        end

        // Randomized fault configurations
        for (int r = 0; r < 10; r++) begin
            en  = 1'($urandom_range(0, 1) | (r < 6));
            ch  = 2'($urandom_range(0, 3));
            net = 4'($urandom_range(0, 11));
            v   = 1'($urandom_range(0, 1));
            model(16'hACE1, 64, en, ch, net, v, s, d, f);
            gold = ($urandom_range(0, 1) != 0) ? s : 8'($urandom);
            do_run(en, ch, net, v, gold, 0, bc);
            check_run($sformatf("rnd%0d", r), en, ch, net, v, gold, bc);
        end

        // Abort with simultaneous start at cycle 20 -> IDLE
        @(negedge clk);
        start = 1; flt_en = 0;
        @(negedge clk);
        start = 0;
        repeat (19) @(negedge clk);
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        @(negedge clk);
        chk("abort_idle_busy", busy, 0);
        do_run(0, 0, 0, 0, ff_sig, 0, bc);
        check_run("after_abort", 0, 0, 0, 0, ff_sig, bc);

        // Reset in the middle of a faulted run
        @(negedge clk);
        start = 1; flt_en = 1; flt_chan = 0; flt_net = 4'd7; flt_val = 0;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_pass", pass, 0);
        chk("mrst_det", detected, 0);
        chk("mrst_sig", signature, 0);
        chk("mrst_ffi", first_fail_idx, 0);
        rst_n = 1;
        @(negedge clk);
        chk("mrst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
